// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM states and default operand width shared with the serial adder bench
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
endpackage

// File: rtl/sipo_shreg.sv
// sipo_shreg: LSB-first serial-in shift register with bit counter; done flags the WIDTH-th bit
module sipo_shreg
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] word,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [WIDTH-2:0] data;
  logic [CW-1:0]    count;
  // word is the fully assembled value as it stands once this cycle's bit is taken
  assign word = {din, data};
  assign busy = count != '0;
  assign done = shift && busy && count == LAST;
  always_ff @(posedge clk) begin
    if (!reset) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= (WIDTH-1)'(din) << (WIDTH - 2);
      count <= CW'(1);
    end else if (shift && busy) begin
      data  <= word[WIDTH-1:1];
      count <= done ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/serial_sum_deser.sv
// serial_sum_deser: deserialises an LSB-first serial sum into a held parallel result.
// Optional parity_out enabled by defining SERIAL_DESER_PARITY_EN.
module serial_sum_deser
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             start,
  input  logic             sum_in,
  input  logic             cout_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             abort_pulse,
`ifdef SERIAL_DESER_PARITY_EN
  output logic             overrun,
  output logic             parity_out
`else
  output logic             overrun
`endif
);
  state_t           state, state_nx;
  logic             load, shift, busy, done, capture, drop;
  logic [WIDTH-1:0] word;
  assign load  = bit_valid & start;
  assign shift = bit_valid & ~start;
  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (sum_in),
    .word  (word),
    .busy  (busy),
    .done  (done)
  );
  // a completed word overwrites the output unless one is still held and unaccepted
  always_comb begin
    capture  = done && (state != HOLD || out_ready);
    drop     = done && state == HOLD && !out_ready;
    state_nx = capture ? HOLD :
               (state == HOLD && out_ready) ? ((load || busy) ? SHIFT : IDLE) :
               (state == IDLE && load) ? SHIFT : state;
  end
  assign out_valid = state == HOLD;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      result      <= '0;
      carry_out   <= 1'b0;
      abort_pulse <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nx;
      abort_pulse <= load && busy;
      if (drop) overrun <= 1'b1;
      if (capture) begin
        result    <= word;
        carry_out <= cout_in;
      end
    end
  end
`ifdef SERIAL_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) parity_out <= 1'b0;
    else if (capture) parity_out <= ^word ^ cout_in;
  end
`endif
endmodule

// File: tb/tb_serial_sum_deser.sv
// tb_serial_sum_deser: directed and randomized checks of serial_sum_deser (WIDTH=4) against a bit-list model
module tb_serial_sum_deser;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         bit_valid = 1'b0, start = 1'b0, sum_in = 1'b0, cout_in = 1'b0, out_ready = 1'b0;
  logic         out_valid, carry_out, abort_pulse, overrun;
  logic [W-1:0] result;
`ifdef SERIAL_DESER_PARITY_EN
  logic         parity_out;
`endif
  int total = 0;
  int bad = 0;
  // model: collected bits plus the output-side view
  int           m_cnt;
  int           m_acc;
  logic         m_valid, m_carry, m_abort, m_ov, m_par;
  logic [W-1:0] m_result;

  serial_sum_deser #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (bit_valid),
    .start       (start),
    .sum_in      (sum_in),
    .cout_in     (cout_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .result      (result),
    .carry_out   (carry_out),
    .abort_pulse (abort_pulse),
`ifdef SERIAL_DESER_PARITY_EN
    .overrun     (overrun),
    .parity_out  (parity_out)
`else
    .overrun     (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic done;
    logic v_old;
    done = 1'b0;
    if (!reset) begin
      m_cnt = 0; m_acc = 0; m_valid = 0; m_result = '0; m_carry = 0; m_abort = 0; m_ov = 0; m_par = 0;
      return;
    end
    m_abort = 1'b0;
    if (bit_valid && start) begin
      m_abort = m_cnt > 0;
      m_acc   = int'(sum_in);
      m_cnt   = 1;
    end else if (bit_valid && m_cnt > 0) begin
      m_acc = m_acc + (int'(sum_in) << m_cnt);
      m_cnt++;
      if (m_cnt == W) begin
        done  = 1'b1;
        m_cnt = 0;
      end
    end
    v_old = m_valid;
    if (v_old && out_ready) m_valid = 1'b0;
    if (done) begin
      if (!v_old || out_ready) begin
        m_valid  = 1'b1;
        m_result = W'(m_acc);
        m_carry  = cout_in;
        m_par    = (^m_result) ^ cout_in;
      end else m_ov = 1'b1;
    end
  endtask

  task automatic step(input logic bv, input logic st, input logic s, input logic c, input logic rdy);
    bit_valid = bv; start = st; sum_in = s; cout_in = c; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("result", 32'(result), 32'(m_result));
    check("carry_out", 32'(carry_out), 32'(m_carry));
    check("abort_pulse", 32'(abort_pulse), 32'(m_abort));
    check("overrun", 32'(overrun), 32'(m_ov));
`ifdef SERIAL_DESER_PARITY_EN
    check("parity_out", 32'(parity_out), 32'(m_par));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic c, input logic rdy_last, input logic rdy);
    for (int i = 0; i < W; i++)
      step(1, i == 0, w[i], (i == W-1) ? c : 1'b0, (i == W-1) ? rdy_last : rdy);
  endtask

  initial begin
    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_ovr", 32'(overrun), 0);
    // 11 + 6 = 17: sum bits 0001, carry 1
    send_word(4'b0001, 1'b1, 1'b1, 1'b1);
    check("d1_result", 32'(result), 32'h1);
    check("d1_carry", 32'(carry_out), 1);
    check("d1_valid", 32'(out_valid), 1);
    step(0, 0, 0, 0, 1);
    check("d1_valid_drop", 32'(out_valid), 0);
    // 1,1,0,1 with idle gaps
    step(1, 1, 1, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    check("d2_pre_valid", 32'(out_valid), 0);
    step(1, 0, 1, 0, 0);
    check("d2_valid", 32'(out_valid), 1);
    check("d2_result", 32'(result), 32'hB);
    check("d2_carry", 32'(carry_out), 0);
    step(0, 0, 0, 0, 0);
    check("d2_hold", 32'(result), 32'hB);
    step(0, 0, 0, 0, 1);
    // abort after 2 bits, then 0,1,1,0
    step(1, 1, 1, 0, 1); step(1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 1);
    check("d3_abort", 32'(abort_pulse), 1);
    step(1, 0, 1, 0, 1);
    check("d3_abort_end", 32'(abort_pulse), 0);
    step(1, 0, 1, 0, 1); step(1, 0, 0, 0, 1);
    check("d3_result", 32'(result), 32'h6);
    step(0, 0, 0, 0, 1);
    // overrun: second word dropped while first is held
    send_word(4'b0011, 1'b0, 1'b0, 1'b0);
    send_word(4'b0101, 1'b0, 1'b0, 1'b0);
    check("d4_result", 32'(result), 32'h3);
    check("d4_ovr", 32'(overrun), 1);
    step(0, 0, 0, 0, 1);
    check("d4_ovr_sticky", 32'(overrun), 1);
    do_reset();
    check("d5_ovr_rst", 32'(overrun), 0);
    send_word(4'b0011, 1'b0, 1'b0, 1'b0);
    send_word(4'b0101, 1'b0, 1'b1, 1'b0);
    check("d5_result", 32'(result), 32'h5);
    check("d5_ovr", 32'(overrun), 0);
    check("d5_valid", 32'(out_valid), 1);
    step(0, 0, 0, 0, 1);
`ifdef SERIAL_DESER_PARITY_EN
    send_word(4'b1011, 1'b1, 1'b0, 1'b0);
    check("p1_parity", 32'(parity_out), 0);
    step(0, 0, 0, 0, 1);
    send_word(4'b1011, 1'b0, 1'b0, 1'b0);
    check("p0_parity", 32'(parity_out), 1);
    step(0, 0, 0, 0, 1);
`endif
    // randomized traffic, including mid-word and HOLD resets
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 1, 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 4);
    end
    reset = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_sum_deser.md
SERIAL_SUM_DESER -- requirements
Module: serial_sum_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; the legal range is 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port bit_valid, input, 1 bit: sum_in and cout_in carry a valid serial bit this cycle.
REQ-005 SHALL have port start, input, 1 bit: qualified by bit_valid; marks the LSB (bit 0) of a new word.
REQ-006 SHALL have port sum_in, input, 1 bit: serial sum bit, LSB first, taken from the upstream serial adder.
REQ-007 SHALL have port cout_in, input, 1 bit: the serial adder carry, sampled with the final bit of the word.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts result this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: result and carry_out are valid.
REQ-010 SHALL have port result, output, WIDTH bits: the assembled parallel sum.
REQ-011 SHALL have port carry_out, output, 1 bit: the final carry of the word.
REQ-012 SHALL have port abort_pulse, output, 1 bit: a one-cycle pulse when a partial word is discarded.
REQ-013 SHALL have port overrun, output, 1 bit: a sticky flag set when a completed word is dropped.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, SHIFT and HOLD.
REQ-015 IDLE: when bit_valid=1 and start=1, SHALL load sum_in into the shift register, set the bit count to 1, and go to SHIFT; bit_valid without start SHALL be ignored.
REQ-016 SHIFT: on each bit_valid=1 with start=0, SHALL shift right with sum_in entering the MSB and increment the count; bit_valid=0 SHALL stall with no change.
REQ-017 When the bit accepted at an edge is bit number WIDTH, at that same edge the block SHALL load result with the assembled word, load carry_out with cout_in, set out_valid=1, and go to HOLD.
REQ-018 With WIDTH accepted bits, result SHALL equal the (A+B) mod 2^WIDTH value formed by those bits, and carry_out SHALL be bit WIDTH of that sum.
REQ-019 HOLD: result, carry_out and out_valid SHALL be held stable until out_ready=1; on the out_valid && out_ready edge, out_valid SHALL clear.
REQ-020 HOLD SHALL continue accepting serial bits as in IDLE/SHIFT, so collection overlaps the output wait; the result register is separate from the shift register.
REQ-021 If a new word completes in HOLD and out_ready=1 on the same cycle, the new word SHALL replace the output and out_valid SHALL remain 1.
REQ-022 If a new word completes in HOLD with out_ready=0, the new word SHALL be dropped, the held output unchanged, and overrun set to 1.
REQ-023 A start=1 with bit_valid=1 received while a partial word (count 1..WIDTH-1) is in progress SHALL discard the partial word, restart with count 1, and assert abort_pulse for exactly one cycle.
REQ-024 A single-bit sequence SHALL complete only when WIDTH bits have been accepted; there is no timeout.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 With reset=0 at a clock edge, the block SHALL enter state IDLE, clear the count and shift register, and drive out_valid=0, result=0, carry_out=0, abort_pulse=0 and overrun=0.
REQ-027 A reset asserted mid-word or in HOLD SHALL discard all data; no partial result SHALL be emitted after reset.
REQ-028 overrun SHALL be cleared only by reset.

Configuration
REQ-029 With SERIAL_DESER_PARITY_EN defined, the block SHALL add an output parity_out (1 bit), registered with result, equal to the XOR of result and carry_out (even parity over WIDTH+1 bits).
REQ-030 With SERIAL_DESER_PARITY_EN undefined, port parity_out SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE, SHIFT, HOLD) and the constant DEFAULT_WIDTH=8, shared with the upstream serial adder bench.
REQ-032 The shift register and bit counter SHALL be a sub-module named sipo_shreg (parameter WIDTH; load, shift and done ports); the FSM and output register SHALL be in the top module.

Verification (WIDTH=4)
REQ-033 Reset held low for 2 cycles, then released -> all outputs are 0 and the state is IDLE.
REQ-034 Stream sum bits 1,0,0,0 (start on first bit) with cout_in=1 on the last bit, out_ready=1 -> result=4'b0001, carry_out=1 (11+6=17), out_valid high for 1 cycle.
REQ-035 Stream 1,1,0,1 with gaps of bit_valid=0 between bits -> result=4'b1011, carry_out=0, out_valid rises on the edge that samples the 4th bit.
REQ-036 After 2 bits, assert start again and then send 0,1,1,0 -> abort_pulse=1 for one cycle, then result=4'b0110.
REQ-037 Hold out_ready=0 and complete two words (0011, then 0101) -> result stays 0011 and overrun=1; with out_ready=1 at the second word's completion instead -> result=0101 and overrun=0.
REQ-038 With SERIAL_DESER_PARITY_EN defined, result=1011 and carry_out=1 -> parity_out=0; result=1011 and carry_out=0 -> parity_out=1.
